// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame-boundary mode sequencer and geometry checker for sobel_processor
// Tracks vsync/href timing, applies the Sobel/bypass request only at frame start, flags bad line/frame sizes.
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic        i_mode_req,
  input  logic        i_err_clr,
  output logic        o_sobel_enable,
  output logic        o_lb_clear,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic [10:0] o_col_cnt,
  output logic [9:0]  o_row_cnt,
  output logic [15:0] o_frame_count,
  output logic        o_line_err,
  output logic        o_frame_err
);

  localparam logic [10:0] LP_WIDTH   = 11'(IMG_WIDTH);
  localparam logic [9:0]  LP_HEIGHT  = 10'(IMG_HEIGHT);
  localparam logic [10:0] LP_COL_MAX = 11'h7ff;
  localparam logic [9:0]  LP_ROW_MAX = 10'h3ff;

  typedef enum logic [1:0] {WAIT_VS, VBLANK, FRAME, LINE} state_t;

  state_t      r_state;
  logic        r_vsync_d;
  logic        r_href_d;
  logic        r_sobel_enable;
  logic        r_lb_clear;
  logic        r_frame_start;
  logic        r_frame_done;
  logic [10:0] r_col_cnt;
  logic [9:0]  r_row_cnt;
  logic [15:0] r_frame_count;
  logic        r_line_err;
  logic        r_frame_err;

  logic w_vs_rise;
  logic w_href_fall;

  assign w_vs_rise   = i_vsync & ~r_vsync_d;
  assign w_href_fall = ~i_href & r_href_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= WAIT_VS;
      r_vsync_d      <= 1'b0;
      r_href_d       <= 1'b0;
      r_sobel_enable <= 1'b0;
      r_lb_clear     <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_done   <= 1'b0;
      r_col_cnt      <= '0;
      r_row_cnt      <= '0;
      r_frame_count  <= '0;
      r_line_err     <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_vsync_d     <= i_vsync;
      r_href_d      <= i_href;
      r_lb_clear    <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      // Clear comes first so a same-cycle set below takes precedence.
      if (i_err_clr) begin
        r_line_err  <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_vs_rise) begin
        r_lb_clear     <= 1'b1;
        r_frame_start  <= 1'b1;
        r_sobel_enable <= i_mode_req;
        r_row_cnt      <= '0;
        r_col_cnt      <= '0;
        r_state        <= VBLANK;
        // Only a frame that was actually tracked is closed and checked.
        if (r_state == FRAME || r_state == LINE) begin
          r_frame_done  <= 1'b1;
          r_frame_count <= r_frame_count + 16'd1;
          if (r_row_cnt != LP_HEIGHT) r_frame_err <= 1'b1;
          if (r_state == LINE) r_line_err <= 1'b1;
        end
      end else begin
        case (r_state)
          WAIT_VS: r_state <= WAIT_VS;
          VBLANK: begin
            if (!i_vsync) r_state <= FRAME;
          end
          FRAME: begin
            if (i_href) begin
              r_col_cnt <= 11'd1;
              r_state   <= LINE;
            end
          end
          LINE: begin
            if (i_href) begin
              if (r_col_cnt != LP_COL_MAX) r_col_cnt <= r_col_cnt + 11'd1;
            end else if (w_href_fall) begin
              if (r_row_cnt != LP_ROW_MAX) r_row_cnt <= r_row_cnt + 10'd1;
              if (r_col_cnt != LP_WIDTH) r_line_err <= 1'b1;
              r_col_cnt <= '0;
              r_state   <= FRAME;
            end
          end
          default: r_state <= WAIT_VS;
        endcase
      end
    end
  end

  assign o_sobel_enable = r_sobel_enable;
  assign o_lb_clear     = r_lb_clear;
  assign o_frame_start  = r_frame_start;
  assign o_frame_done   = r_frame_done;
  assign o_col_cnt      = r_col_cnt;
  assign o_row_cnt      = r_row_cnt;
  assign o_frame_count  = r_frame_count;
  assign o_line_err     = r_line_err;
  assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb/tb_sobel_frame_ctrl.sv - self-checking bench for sobel_frame_ctrl
// Small geometry keeps frames short; expectations come from a line/frame-level model.
module tb_sobel_frame_ctrl;

  localparam int W = 16;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst, vsync, href, mode_req, err_clr;
  logic        o_sobel_enable, o_lb_clear, o_frame_start, o_frame_done;
  logic [10:0] o_col_cnt;
  logic [9:0]  o_row_cnt;
  logic [15:0] o_frame_count;
  logic        o_line_err, o_frame_err;

  int checks = 0;
  int failures = 0;

  // Reference model: what has been delivered, in lines and frames.
  bit          m_tracking;
  bit          m_sobel, m_le, m_fe;
  int          m_rows;
  logic [15:0] m_fc;

  sobel_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_vsync(vsync), .i_href(href),
    .i_mode_req(mode_req), .i_err_clr(err_clr),
    .o_sobel_enable(o_sobel_enable), .o_lb_clear(o_lb_clear),
    .o_frame_start(o_frame_start), .o_frame_done(o_frame_done),
    .o_col_cnt(o_col_cnt), .o_row_cnt(o_row_cnt), .o_frame_count(o_frame_count),
    .o_line_err(o_line_err), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_tracking = 0; m_sobel = 0; m_le = 0; m_fe = 0; m_rows = 0; m_fc = '0;
  endtask

  task automatic drive_line(input int len, input bit rnd_mode);
    int exp_col;
    href = 1'b1;
    for (int k = 1; k <= len; k++) begin
      if (rnd_mode && $urandom_range(0, 3) == 0) mode_req = 1'($urandom_range(0, 1));
      tick;
      exp_col = m_tracking ? ((k > 2047) ? 2047 : k) : 0;
      checks++;
      if (o_col_cnt !== 11'(exp_col) || o_sobel_enable !== m_sobel) begin
        failures++;
        $display("FAIL line_pixel k=%0d col=%0d sobel=%0b expected col=%0d sobel=%0b",
                 k, o_col_cnt, o_sobel_enable, exp_col, m_sobel);
      end
    end
    href = 1'b0;
    tick;
    if (m_tracking) begin
      if (m_rows < 1023) m_rows++;
      if (len != W) m_le = 1;
    end
    checks++;
    if ({o_row_cnt, o_col_cnt, o_line_err, o_frame_err, o_lb_clear, o_frame_done} !==
        {10'(m_rows), 11'd0, m_le, m_fe, 2'b00}) begin
      failures++;
      $display("FAIL line_end len=%0d row=%0d col=%0d le=%0b fe=%0b lb=%0b fd=%0b expected row=%0d col=0 le=%0b fe=%0b lb=0 fd=0",
               len, o_row_cnt, o_col_cnt, o_line_err, o_frame_err, o_lb_clear, o_frame_done,
               m_rows, m_le, m_fe);
    end
  endtask

  task automatic do_vs(input int high);
    bit intr, exp_done;
    intr = href && m_tracking;
    exp_done = m_tracking;
    if (err_clr) begin m_le = 0; m_fe = 0; end
    if (m_tracking) begin
      m_fc++;
      if (m_rows != H) m_fe = 1;
      if (intr) m_le = 1;
    end
    m_sobel = mode_req; m_tracking = 1; m_rows = 0;
    vsync = 1'b1;
    tick;
    err_clr = 1'b0;
    href = 1'b0;
    checks++;
    if ({o_frame_start, o_lb_clear, o_frame_done, o_sobel_enable, o_line_err, o_frame_err} !==
        {2'b11, exp_done, m_sobel, m_le, m_fe} ||
        o_frame_count !== m_fc || o_row_cnt !== 10'd0 || o_col_cnt !== 11'd0) begin
      failures++;
      $display("FAIL vs_rise fs=%0b lb=%0b fd=%0b sob=%0b le=%0b fe=%0b fc=%0d row=%0d col=%0d expected fs=1 lb=1 fd=%0b sob=%0b le=%0b fe=%0b fc=%0d row=0 col=0",
               o_frame_start, o_lb_clear, o_frame_done, o_sobel_enable, o_line_err, o_frame_err,
               o_frame_count, o_row_cnt, o_col_cnt, exp_done, m_sobel, m_le, m_fe, m_fc);
    end
    for (int i = 1; i < high; i++) begin
      href = 1'($urandom_range(0, 1));
      mode_req = 1'($urandom_range(0, 1));
      tick;
      checks++;
      if ({o_frame_start, o_lb_clear, o_frame_done, o_sobel_enable} !== {3'b000, m_sobel} ||
          o_col_cnt !== 11'd0 || o_row_cnt !== 10'd0) begin
        failures++;
        $display("FAIL vblank_hold fs=%0b lb=%0b fd=%0b sob=%0b col=%0d row=%0d expected 0 0 0 %0b 0 0",
                 o_frame_start, o_lb_clear, o_frame_done, o_sobel_enable, o_col_cnt, o_row_cnt, m_sobel);
      end
    end
    href = 1'b0;
    vsync = 1'b0;
    tick;
    tick;
  endtask

  task automatic pulse_err_clr;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    m_le = 0; m_fe = 0;
    checks++;
    if ({o_line_err, o_frame_err} !== 2'b00) begin
      failures++;
      $display("FAIL err_clr le=%0b fe=%0b expected 0 0", o_line_err, o_frame_err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; vsync = 1'b0; href = 1'b0; mode_req = 1'b0; err_clr = 1'b0;
    tick;
    tick;
    model_reset;
    checks++;
    if ({o_sobel_enable, o_lb_clear, o_frame_start, o_frame_done, o_col_cnt, o_row_cnt,
         o_frame_count, o_line_err, o_frame_err} !== '0) begin
      failures++;
      $display("FAIL reset_state sob=%0b lb=%0b fs=%0b fd=%0b col=%0d row=%0d fc=%0d le=%0b fe=%0b expected all 0",
               o_sobel_enable, o_lb_clear, o_frame_start, o_frame_done, o_col_cnt, o_row_cnt,
               o_frame_count, o_line_err, o_frame_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    mode_req = 1'b0;
    drive_line(W, 0);
    do_vs(3);
    for (int f = 0; f < 2; f++) begin
      repeat (H) drive_line(W, 0);
      do_vs(1 + f * 2);
    end
    checks++;
    if (o_frame_count !== 16'd2 || o_line_err !== 1'b0 || o_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL nominal_two_frames fc=%0d le=%0b fe=%0b expected fc=2 le=0 fe=0",
               o_frame_count, o_line_err, o_frame_err);
    end
  endtask

  task automatic test_mode_switch;
    repeat (3) drive_line(W, 0);
    mode_req = 1'b1;
    repeat (H - 3) drive_line(W, 0);
    mode_req = 1'b1;
    do_vs(2);
    checks++;
    if (o_sobel_enable !== 1'b1) begin
      failures++;
      $display("FAIL mode_switch sobel=%0b expected 1", o_sobel_enable);
    end
  endtask

  task automatic test_short_line;
    for (int l = 0; l < H; l++) drive_line((l == 3) ? W - 1 : W, 1);
    do_vs(2);
    checks++;
    if (o_line_err !== 1'b1 || o_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL short_line le=%0b fe=%0b expected le=1 fe=0", o_line_err, o_frame_err);
    end
    pulse_err_clr;
  endtask

  task automatic test_short_frame;
    repeat (H - 1) drive_line(W, 1);
    err_clr = 1'b1;
    do_vs(1);
    checks++;
    if (o_frame_err !== 1'b1 || o_line_err !== 1'b0) begin
      failures++;
      $display("FAIL short_frame_set_wins fe=%0b le=%0b expected fe=1 le=0", o_frame_err, o_line_err);
    end
    pulse_err_clr;
  endtask

  task automatic test_vs_mid_line;
    repeat (H / 2) drive_line(W, 0);
    href = 1'b1;
    repeat (W / 2) tick;
    do_vs(3);
    checks++;
    if (o_line_err !== 1'b1 || o_frame_err !== 1'b1) begin
      failures++;
      $display("FAIL vs_mid_line le=%0b fe=%0b expected le=1 fe=1", o_line_err, o_frame_err);
    end
    pulse_err_clr;
  endtask

  task automatic test_col_saturation;
    drive_line(2050, 0);
    repeat (H - 1) drive_line(W, 0);
    do_vs(1);
    pulse_err_clr;
  endtask

  task automatic test_random;
    int nlines, len;
    for (int f = 0; f < 15; f++) begin
      nlines = H - 1 + $urandom_range(0, 2);
      for (int l = 0; l < nlines; l++) begin
        len = ($urandom_range(0, 4) == 0) ? W - 2 + $urandom_range(0, 4) : W;
        drive_line(len, 1);
        if ($urandom_range(0, 9) == 0) pulse_err_clr;
      end
      if ($urandom_range(0, 3) == 0) begin
        href = 1'b1;
        repeat ($urandom_range(1, W)) tick;
      end
      mode_req = 1'($urandom_range(0, 1));
      err_clr = 1'($urandom_range(0, 2) == 0);
      do_vs($urandom_range(1, 4));
    end
  endtask

  task automatic test_rst_mid_frame;
    drive_line(W - 1, 0);
    repeat (2) drive_line(W, 0);
    href = 1'b1;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    model_reset;
    checks++;
    if ({o_sobel_enable, o_lb_clear, o_frame_start, o_frame_done, o_col_cnt, o_row_cnt,
         o_frame_count, o_line_err, o_frame_err} !== '0) begin
      failures++;
      $display("FAIL rst_mid_frame sob=%0b lb=%0b fs=%0b fd=%0b col=%0d row=%0d fc=%0d le=%0b fe=%0b expected all 0",
               o_sobel_enable, o_lb_clear, o_frame_start, o_frame_done, o_col_cnt, o_row_cnt,
               o_frame_count, o_line_err, o_frame_err);
    end
    rst = 1'b0;
    href = 1'b0;
    tick;
    drive_line(W, 0);
    mode_req = 1'b0;
    do_vs(2);
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_mode_switch;
    test_short_line;
    test_short_frame;
    test_vs_mid_line;
    test_col_saturation;
    test_random;
    test_rst_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame-level sequencer in front of `sobel_processor`. It tracks camera `vsync`/`href` timing, counts pixels per line and lines per frame, and latches the user's Sobel/bypass request only at frame boundaries so a frame is never half-filtered. It issues a line-buffer clear pulse at each frame start and raises sticky geometry-error flags when the sensor delivers lines or frames of the wrong size. It sits between the camera capture logic and the `sobel_processor` `sobel_enable` input.

## Interface
- `IMG_WIDTH`, 640: expected pixels (href-high cycles) per line.
- `IMG_HEIGHT`, 480: expected lines per frame.
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `vsync`  in  1  frame sync; high = vertical blanking; its rising edge ends the current frame.
- `href`  in  1  line valid; high for each active pixel.
- `mode_req`  in  1  requested mode, 1 = Sobel, 0 = bypass; level, asynchronous to frames.
- `err_clr`  in  1  clears `line_err` and `frame_err`.
- `sobel_enable`  out  1  applied mode; changes only at a frame start.
- `lb_clear`  out  1  one-cycle pulse at frame start, used to flush line buffers.
- `frame_start`  out  1  one-cycle pulse, coincident with `lb_clear`.
- `frame_done`  out  1  one-cycle pulse when a tracked frame ends.
- `col_cnt`  out  11  href-high cycles seen in the current line; saturates at 2047.
- `row_cnt`  out  10  lines completed in the current frame; saturates at 1023.
- `frame_count`  out  16  completed frames; wraps 65535 -> 0.
- `line_err`  out  1  sticky: a line ended with `col_cnt != IMG_WIDTH`.
- `frame_err`  out  1  sticky: a frame ended with `row_cnt != IMG_HEIGHT`.

## Operation
- Edge detection uses registered `vsync_d` and `href_d`:
  - `vs_rise = vsync & ~vsync_d`
  - `href_fall = ~href & href_d`
- The FSM has four states: `WAIT_VS`, `VBLANK`, `FRAME`, `LINE`.
  - `WAIT_VS` (reset state): `href` is ignored. On `vs_rise`, go to `VBLANK`. No `frame_done` is issued, because no frame was tracked.
  - `VBLANK`: when `vsync` falls, go to `FRAME`.
  - `FRAME`:
    - `href`=1 -> `LINE`, and `col_cnt` is set to 1.
    - `vs_rise` -> frame end.
  - `LINE`:
    - Each `href`=1 cycle increments `col_cnt`.
    - On `href_fall`: `row_cnt`++, `line_err` is set if `col_cnt != IMG_WIDTH`, then `col_cnt` <= 0 and go to `FRAME`.
- Frame end (`vs_rise` while in `FRAME` or `LINE`):
  - Pulse `frame_done` and increment `frame_count`.
  - Set `frame_err` if `row_cnt != IMG_HEIGHT`, then go to `VBLANK`.
  - If the state was `LINE`, the interrupted line is a short line: set `line_err`, and that line is not added to `row_cnt`.
- Frame start happens on every `vs_rise`, including the first one from `WAIT_VS`:
  - Pulse `lb_clear` and `frame_start`.
  - `sobel_enable <= mode_req` as sampled in the `vs_rise` cycle.
  - `row_cnt <= 0`, `col_cnt <= 0`.
- `mode_req` changes at any other time have no effect until the next `vs_rise`.
- The error flags are sticky until `err_clr`. If `err_clr` and a set condition occur in the same cycle, the set wins.
- A `vsync`/`href` overlap without a rising edge (`vsync` held high while `href` toggles) is ignored; the state stays `VBLANK`.
- `rst` mid-frame:
  - All outputs return to reset values and the state goes to `WAIT_VS`.
  - The partial frame is discarded: no `frame_done` and no errors are reported for it.

## Timing
- All outputs are registered. Reset values: `sobel_enable`=0, `lb_clear`=0, `frame_start`=0, `frame_done`=0, `col_cnt`=0, `row_cnt`=0, `frame_count`=0, `line_err`=0, `frame_err`=0.
- Pulses and updates appear one cycle after the input edge:
  - `vs_rise` detected in cycle N -> `lb_clear`, `frame_start`, `frame_done` and the new `sobel_enable` are all visible in cycle N+1.
  - `href_fall` in cycle N -> `row_cnt` and `line_err` update in cycle N+1.
- `col_cnt` lags `href` by one cycle: after k consecutive `href` cycles, `col_cnt` = k on the following cycle.
- `frame_done` and `frame_start` for back-to-back frames coincide in the same cycle.
- Minimum `vsync` high time: 1 cycle.

## Test plan
- Reset, then 2 frames of 480 lines × 640 `href` cycles -> the first `vs_rise` gives `frame_start` only; `frame_done` ×2, `frame_count`=2, `line_err`=0, `frame_err`=0.
- Toggle `mode_req` 0->1 mid-frame -> `sobel_enable` stays 0 until the cycle after the next `vs_rise`, then becomes 1 together with `lb_clear`.
- One 639-pixel line in an otherwise nominal frame -> `line_err`=1 from the cycle after that `href` fall; `frame_err`=0; `err_clr` -> 0.
- Frame of 479 lines -> `frame_err`=1 one cycle after the ending `vs_rise`; `err_clr` asserted in the same cycle as a new set -> flag stays 1.
- `vs_rise` while `href` is high at pixel 300 -> `line_err`=1, `row_cnt` not incremented, `frame_done` pulses, next state `VBLANK`.
- `rst` at line 200 -> all outputs 0; the next `vs_rise` gives `frame_start`=1 and `frame_done`=0.
